// File: rtl/acc_flag_unit.sv
// Accumulator/flag register file around an external ALU: IDLE -> EXEC -> WB, one op per three cycles.
// op_ready is high only in IDLE; done (or err for an undefined opcode) pulses in WB, two cycles after acceptance.
module acc_flag_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] op_data,
    input  logic             flag_clr,
    output logic [3:0]       alu_oper,
    output logic [WIDTH-1:0] alu_data,
    output logic [WIDTH-1:0] alu_acc,
    output logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_flag_c,
    input  logic             alu_flag_z,
    input  logic             alu_flag_s,
    input  logic             alu_flag_v,
    input  logic             alu_flag_p,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_s,
    output logic             flag_v,
    output logic             flag_p,
    output logic             done,
    output logic             err
);

    localparam logic [3:0] moveCode      = 4'h0;
    localparam logic [3:0] incrementCode = 4'h1;
    localparam logic [3:0] decrementCode = 4'h2;
    localparam logic [3:0] addCode       = 4'h3;
    localparam logic [3:0] subCode       = 4'h4;
    localparam logic [3:0] addcCode      = 4'h5;
    localparam logic [3:0] subcCode      = 4'h6;
    localparam logic [3:0] andCode       = 4'h7;
    localparam logic [3:0] orCode        = 4'h8;
    localparam logic [3:0] xorCode       = 4'h9;
    localparam logic [3:0] notCode       = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic             op_def_q;
    logic             accept;
    logic             wr_en;
    logic             loads_c;
    logic             loads_v;

    function automatic logic is_defined(input logic [3:0] code);
        case (code)
            moveCode, incrementCode, decrementCode, addCode, subCode,
            addcCode, subcCode, andCode, orCode, xorCode, notCode: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_carry_op(input logic [3:0] code);
        case (code)
            incrementCode, decrementCode, addCode, subCode,
            addcCode, subcCode: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_ovf_op(input logic [3:0] code);
        case (code)
            addCode, subCode, addcCode, subcCode: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                // rst gating keeps op_ready low during the asynchronous reset window
                op_ready = !rst;
                if (op_valid && !rst) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = WB;
            end
            WB: begin
                state_nxt = IDLE;
                done      = op_def_q;
                err       = !op_def_q;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = op_valid && op_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 4'h0;
            data_q   <= '0;
            op_def_q <= 1'b0;
        end else if (accept) begin
            op_q     <= op_code;
            data_q   <= op_data;
            op_def_q <= is_defined(op_code);
        end
    end

    assign wr_en   = (state == EXEC) && op_def_q;
    assign loads_c = wr_en && is_carry_op(op_q);
    assign loads_v = wr_en && is_ovf_op(op_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            flag_z <= 1'b0;
            flag_s <= 1'b0;
            flag_p <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            if (wr_en) begin
                acc    <= alu_out;
                flag_z <= alu_flag_z;
                flag_s <= alu_flag_s;
                flag_p <= alu_flag_p;
            end
            if (loads_v) begin
                flag_v <= alu_flag_v;
            end
        end
    end

    // Clearing at the acceptance edge means the accepted op already sees carry-in 0; in EXEC the write-back wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c <= 1'b0;
        end else if (loads_c) begin
            flag_c <= alu_flag_c;
        end else if (flag_clr && (state != EXEC)) begin
            flag_c <= 1'b0;
        end
    end

    assign alu_oper     = op_q;
    assign alu_data     = data_q;
    assign alu_acc      = acc;
    assign alu_carry_in = flag_c;

endmodule

// File: tb/tb_acc_flag_unit.sv
// Bench for acc_flag_unit: plays the ALU, runs a directed vector table, corner sequences and random ops against a model.
module tb_acc_flag_unit;

    localparam int WIDTH = 8;

    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_DEC  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_ADDC = 4'h5;
    localparam logic [3:0] OP_SUBC = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_BAD  = 4'hF;

    logic             clk;
    logic             rst;
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] op_data;
    logic             flag_clr;
    logic [3:0]       alu_oper;
    logic [WIDTH-1:0] alu_data;
    logic [WIDTH-1:0] alu_acc;
    logic             alu_carry_in;
    logic [WIDTH-1:0] alu_out;
    logic             alu_flag_c, alu_flag_z, alu_flag_s, alu_flag_v, alu_flag_p;
    logic [WIDTH-1:0] acc;
    logic             flag_c, flag_z, flag_s, flag_v, flag_p;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    // model state
    int m_acc;
    bit m_c, m_z, m_s, m_v, m_p;

    acc_flag_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_data(op_data),
        .flag_clr(flag_clr),
        .alu_oper(alu_oper), .alu_data(alu_data), .alu_acc(alu_acc), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out),
        .alu_flag_c(alu_flag_c), .alu_flag_z(alu_flag_z), .alu_flag_s(alu_flag_s),
        .alu_flag_v(alu_flag_v), .alu_flag_p(alu_flag_p),
        .acc(acc),
        .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s), .flag_v(flag_v), .flag_p(flag_p),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU. Flags that the unit must not load are driven to misleading values.
    logic [8:0] alu_w;
    always_comb begin
        alu_w      = 9'd0;
        alu_out    = 8'hA5;
        alu_flag_c = ~alu_carry_in;
        alu_flag_v = ~alu_data[0];
        case (alu_oper)
            OP_MOV:  alu_out = alu_data;
            OP_INC:  begin alu_w = {1'b0, alu_acc} + 9'd1; alu_out = alu_w[7:0]; alu_flag_c = alu_w[8]; end
            OP_DEC:  begin alu_w = {1'b0, alu_acc} - 9'd1; alu_out = alu_w[7:0]; alu_flag_c = alu_w[8]; end
            OP_ADD:  begin
                alu_w = {1'b0, alu_acc} + {1'b0, alu_data};
                alu_out = alu_w[7:0]; alu_flag_c = alu_w[8];
                alu_flag_v = (alu_acc[7] == alu_data[7]) && (alu_w[7] != alu_acc[7]);
            end
            OP_SUB:  begin
                alu_w = {1'b0, alu_acc} - {1'b0, alu_data};
                alu_out = alu_w[7:0]; alu_flag_c = alu_w[8];
                alu_flag_v = (alu_acc[7] != alu_data[7]) && (alu_w[7] != alu_acc[7]);
            end
            OP_ADDC: begin
                alu_w = {1'b0, alu_acc} + {1'b0, alu_data} + {8'd0, alu_carry_in};
                alu_out = alu_w[7:0]; alu_flag_c = alu_w[8];
                alu_flag_v = (alu_acc[7] == alu_data[7]) && (alu_w[7] != alu_acc[7]);
            end
            OP_SUBC: begin
                alu_w = {1'b0, alu_acc} - {1'b0, alu_data} - {8'd0, alu_carry_in};
                alu_out = alu_w[7:0]; alu_flag_c = alu_w[8];
                alu_flag_v = (alu_acc[7] != alu_data[7]) && (alu_w[7] != alu_acc[7]);
            end
            OP_AND:  alu_out = alu_acc & alu_data;
            OP_OR:   alu_out = alu_acc | alu_data;
            OP_XOR:  alu_out = alu_acc ^ alu_data;
            OP_NOT:  alu_out = ~alu_acc;
            default: alu_flag_v = 1'b1;
        endcase
        alu_flag_z = (alu_out == 8'd0);
        alu_flag_s = alu_out[7];
        alu_flag_p = ~^alu_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: plain integers, signed range tests for overflow.
    task automatic model_op(input int op, input int d, input bit clr_acc, input bit clr_wb, output bit defined);
        int cin, t, sa, sd, st;
        bit has_c, has_v;
        if (clr_acc) m_c = 1'b0;
        cin = int'(m_c);
        defined = (op <= 10);
        has_c = 1'b0; has_v = 1'b0; t = 0; st = 0;
        sa = (m_acc > 127) ? m_acc - 256 : m_acc;
        sd = (d > 127) ? d - 256 : d;
        case (op)
            0:  t = d;
            1:  begin t = m_acc + 1; has_c = 1'b1; end
            2:  begin t = m_acc - 1; has_c = 1'b1; end
            3:  begin t = m_acc + d; st = sa + sd; has_c = 1'b1; has_v = 1'b1; end
            4:  begin t = m_acc - d; st = sa - sd; has_c = 1'b1; has_v = 1'b1; end
            5:  begin t = m_acc + d + cin; st = sa + sd + cin; has_c = 1'b1; has_v = 1'b1; end
            6:  begin t = m_acc - d - cin; st = sa - sd - cin; has_c = 1'b1; has_v = 1'b1; end
            7:  t = m_acc & d;
            8:  t = m_acc | d;
            9:  t = m_acc ^ d;
            10: t = 255 - m_acc;
            default: t = m_acc;
        endcase
        if (defined) begin
            if (has_c) m_c = (t > 255) || (t < 0);
            if (has_v) m_v = (st > 127) || (st < -128);
            m_acc = t & 255;
            m_z = (m_acc == 0);
            m_s = (m_acc >= 128);
            m_p = (($countones(m_acc) % 2) == 0);
        end
        if (clr_wb) m_c = 1'b0;
    endtask

    task automatic model_reset();
        m_acc = 0; m_c = 0; m_z = 0; m_s = 0; m_v = 0; m_p = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_acc"},    32'(acc),    32'(m_acc));
        check({tag, "_flag_c"}, 32'(flag_c), 32'(m_c));
        check({tag, "_flag_z"}, 32'(flag_z), 32'(m_z));
        check({tag, "_flag_s"}, 32'(flag_s), 32'(m_s));
        check({tag, "_flag_v"}, 32'(flag_v), 32'(m_v));
        check({tag, "_flag_p"}, 32'(flag_p), 32'(m_p));
    endtask

    // One full operation; inputs driven and outputs sampled on the falling edge.
    task automatic run_op(input logic [3:0] op, input logic [7:0] d, input bit clr_acc,
                          input bit clr_exec, input bit clr_wb, input bit hold, output bit saw_err);
        bit defined;
        bit cin_exp;
        @(negedge clk);
        check("idle_ready", 32'(op_ready), 32'd1);
        op_valid = 1'b1; op_code = op; op_data = d; flag_clr = clr_acc;
        cin_exp = clr_acc ? 1'b0 : m_c;
        @(negedge clk);
        check("exec_ready", 32'(op_ready), 32'd0);
        check("exec_done_err", 32'({done, err}), 32'd0);
        check("exec_alu_acc", 32'(alu_acc), 32'(m_acc));
        check("exec_carry_in", 32'(alu_carry_in), 32'(cin_exp));
        op_valid = hold; op_code = ~op; op_data = ~d; flag_clr = clr_exec;
        #1;
        check("exec_alu_oper", 32'(alu_oper), 32'(op));
        check("exec_alu_data", 32'(alu_data), 32'(d));
        model_op(int'(op), int'(d), clr_acc, clr_wb, defined);
        @(negedge clk);
        check("wb_ready", 32'(op_ready), 32'd0);
        check("wb_done", 32'(done), 32'(defined));
        check("wb_err", 32'(err), 32'(!defined));
        saw_err = err;
        flag_clr = clr_wb;
        @(negedge clk);
        op_valid = 1'b0; flag_clr = 1'b0;
        check("post_done_err", 32'({done, err}), 32'd0);
        check_regs("post");
    endtask

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] d;
        logic       clr;
        logic [7:0] e_acc;
        logic       e_c, e_z, e_s, e_v, e_p, e_err;
    } vec_t;

    vec_t vecs [20];
    bit   e_tmp;

    initial begin
        vecs[0]  = '{OP_MOV,  8'h80, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_MOV,  8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{OP_INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{OP_MOV,  8'h10, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_ADDC, 8'h20, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_MOV,  8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{OP_INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{OP_MOV,  8'h10, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_ADDC, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{OP_MOV,  8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{OP_INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{OP_MOV,  8'hF0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{OP_AND,  8'h0F, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{OP_MOV,  8'h7F, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{OP_ADD,  8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{OP_SUB,  8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{OP_BAD,  8'h55, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{OP_XOR,  8'hFF, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{OP_DEC,  8'h00, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{OP_NOT,  8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; op_valid = 1'b0; op_code = 4'h0; op_data = 8'h00; flag_clr = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_ready", 32'(op_ready), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check_regs("rst");
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", 32'(op_ready), 32'd1);

        // directed table, applied in sequence from reset
        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].op, vecs[i].d, vecs[i].clr, 1'b0, 1'b0, 1'b0, e_tmp);
            check($sformatf("vec%0d_acc", i),    32'(acc),    32'(vecs[i].e_acc));
            check($sformatf("vec%0d_flags", i),  32'({flag_c, flag_z, flag_s, flag_v, flag_p}),
                  32'({vecs[i].e_c, vecs[i].e_z, vecs[i].e_s, vecs[i].e_v, vecs[i].e_p}));
            check($sformatf("vec%0d_err", i),    32'(e_tmp), 32'(vecs[i].e_err));
        end

        // flag_clr alone in IDLE
        run_op(OP_MOV, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, e_tmp);
        run_op(OP_INC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, e_tmp);
        check("seq_c_set", 32'(flag_c), 32'd1);
        @(negedge clk); flag_clr = 1'b1;
        @(negedge clk); flag_clr = 1'b0;
        m_c = 1'b0;
        check("seq_idle_clr", 32'(flag_c), 32'd0);

        // flag_clr during EXEC ignored, op_valid held through EXEC/WB not re-accepted
        run_op(OP_MOV, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, e_tmp);
        run_op(OP_INC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, e_tmp);
        run_op(OP_MOV, 8'h12, 1'b0, 1'b1, 1'b0, 1'b1, e_tmp);
        check("seq_exec_clr_ignored", 32'(flag_c), 32'd1);
        check("seq_hold_acc", 32'(acc), 32'h12);
        run_op(OP_BAD, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, e_tmp);
        check("seq_bad_err", 32'(e_tmp), 32'd1);
        check("seq_bad_acc", 32'(acc), 32'h12);

        // flag_clr during WB clears carry
        run_op(OP_MOV, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, e_tmp);
        check("seq_wb_clr", 32'(flag_c), 32'd0);

        // subtract with borrow-in
        run_op(OP_MOV, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, e_tmp);
        run_op(OP_DEC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, e_tmp);
        run_op(OP_SUBC, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, e_tmp);
        check("seq_subc_acc", 32'(acc), 32'hEF);
        check("seq_subc_c", 32'(flag_c), 32'd0);

        // reset in the middle of EXEC
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MOV; op_data = 8'h55;
        @(negedge clk);
        op_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_acc", 32'(acc), 32'd0);
        check("midrst_flags", 32'({flag_c, flag_z, flag_s, flag_v, flag_p}), 32'd0);
        check("midrst_ready", 32'(op_ready), 32'd0);
        check("midrst_done_err", 32'({done, err}), 32'd0);
        @(negedge clk);
        check("midrst_hold_done_err", 32'({done, err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rel_ready", 32'(op_ready), 32'd1);
        check("midrst_rel_done_err", 32'({done, err}), 32'd0);
        check_regs("midrst");

        // random operations against the model
        for (int i = 0; i < 200; i++) begin
            run_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1), e_tmp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_flag_unit.md
ACC_FLAG_UNIT -- requirements
Module: acc_flag_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data path and accumulator width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port op_valid, input, 1 bit: the requester presents an operation.
REQ-005 The block SHALL have port op_ready, output, 1 bit: the block can accept an operation.
REQ-006 The block SHALL have port op_code, input, 4 bits: the ALU opcode, using the constants in alu_defs.sv.
REQ-007 The block SHALL have port op_data, input, WIDTH bits: the operand.
REQ-008 The block SHALL have port flag_clr, input, 1 bit: clears the carry flag register.
REQ-009 The block SHALL have port alu_oper, output, 4 bits: opcode driven to the ALU.
REQ-010 The block SHALL have port alu_data, output, WIDTH bits: operand driven to the ALU.
REQ-011 The block SHALL have port alu_acc, output, WIDTH bits: accumulator value driven to the ALU.
REQ-012 The block SHALL have port alu_carry_in, output, 1 bit: carry flag register value driven to the ALU.
REQ-013 The block SHALL have port alu_out, input, WIDTH bits: ALU result.
REQ-014 The block SHALL have ports alu_flag_c, alu_flag_z, alu_flag_s, alu_flag_v, alu_flag_p, each input, 1 bit: the ALU flags.
REQ-015 The block SHALL have port acc, output, WIDTH bits: the accumulator register.
REQ-016 The block SHALL have ports flag_c, flag_z, flag_s, flag_v, flag_p, each output, 1 bit: the flag registers.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse when a write-back completes.
REQ-018 The block SHALL have port err, output, 1 bit: one-cycle pulse when an opcode is undefined.

Function
REQ-019 The block SHALL implement an FSM with three states, IDLE, EXEC and WB.
REQ-020 The FSM SHALL go from IDLE to EXEC on op_valid and op_ready, from EXEC to WB unconditionally, and from WB to IDLE unconditionally.
REQ-021 op_ready SHALL be 1 only in IDLE; op_valid in EXEC or WB SHALL be ignored.
REQ-022 On acceptance, op_code and op_data SHALL be latched into internal registers, so alu_oper and alu_data are stable throughout EXEC.
REQ-023 alu_acc SHALL equal acc at all times, and alu_carry_in SHALL equal flag_c at all times.
REQ-024 At the rising edge ending EXEC, for a defined opcode, acc SHALL load alu_out and flag_z, flag_s and flag_p SHALL load the corresponding ALU flags.
REQ-025 flag_c SHALL load alu_flag_c only for incrementCode, decrementCode, addCode, subCode, addcCode and subcCode, and SHALL keep its value otherwise.
REQ-026 flag_v SHALL load alu_flag_v only for addCode, subCode, addcCode and subcCode, and SHALL keep its value otherwise.
REQ-027 For an opcode not defined in alu_defs.sv, acc and all flags SHALL keep their values, and err SHALL pulse high in WB instead of done.
REQ-028 done SHALL be 1 exactly during WB for a defined opcode, giving a latency from the acceptance edge to done of two cycles and a throughput of one operation per three cycles.
REQ-029 flag_clr high in IDLE or WB SHALL clear flag_c at the next edge.
REQ-030 flag_clr in the same cycle as an acceptance SHALL clear flag_c, so that the accepted operation sees alu_carry_in = 0.
REQ-031 flag_clr during EXEC SHALL be ignored; the write-back has priority.
REQ-032 The block SHALL contain no arithmetic of its own; all results come from alu_out.

Reset
REQ-033 While rst is high, asynchronously: state SHALL be IDLE, acc = 0, all flags = 0, done = 0, err = 0, op_ready = 0.
REQ-034 op_ready SHALL go to 1 in the first cycle after rst falls.
REQ-035 Assertion of rst during EXEC or WB SHALL discard the in-flight operation with no done or err pulse.

Verification
REQ-036 After reset, moveCode with op_data 0x80 SHALL give done two cycles after acceptance, acc = 0x80, flag_s = 1, flag_z = 0, flag_p = 0, and flag_c unchanged at 0.
REQ-037 With acc = 0xFF, incrementCode SHALL give acc = 0x00, flag_c = 1, flag_z = 1, flag_p = 1.
REQ-038 With flag_c = 1 and acc = 0x10, addcCode with op_data 0x20 SHALL give acc = 0x31 and flag_c = 0; with flag_clr pulsed at acceptance instead, it SHALL give acc = 0x30.
REQ-039 With flag_c = 1, andCode with op_data 0x0F on acc 0xF0 SHALL give acc = 0x00, flag_z = 1, and flag_c still 1.
REQ-040 rst asserted mid-EXEC SHALL give acc = 0 immediately, no done, and op_ready = 1 after rst falls.
REQ-041 An undefined opcode (any code not defined in alu_defs.sv) SHALL give an err pulse, no done, and acc and flags unchanged; op_valid held high during EXEC and WB SHALL not be accepted.
